// File: rtl/convcor_pkg.sv
// Shared constants, FSM state type and convolution schedule bounds for the Convcor sequencer.
package convcor_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 18;
  localparam int unsigned N     = 3;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_CORR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_e;

  // First/last k contributing to y[n] = sum a[k]*b[n-k] for an nn-sample frame.
  function automatic int unsigned conv_k_first(input int unsigned n, input int unsigned nn);
    return (n >= nn) ? n - nn + 1 : 0;
  endfunction

  function automatic int unsigned conv_k_last(input int unsigned n, input int unsigned nn);
    return (n < nn) ? n : nn - 1;
  endfunction

endpackage

// File: rtl/cplx_mac.sv
// Single complex multiply-accumulate; optional conjugation of the b operand.
module cplx_mac #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 conj_b,
  input  logic [2*DW-1:0]      a,
  input  logic [2*DW-1:0]      b,
  output logic [2*ACC_W-1:0]   acc
);

  logic signed [DW-1:0]    ar, ai, br, bi;
  logic signed [2*DW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [2*DW:0]    re_p, im_p;
  logic signed [ACC_W-1:0] re_ext, im_ext, re_base, im_base;
  logic signed [ACC_W-1:0] re_q, im_q, re_d, im_d;

  assign ar = a[2*DW-1:DW];
  assign ai = a[DW-1:0];
  assign br = b[2*DW-1:DW];
  assign bi = b[DW-1:0];

  assign p_rr = ar * br;
  assign p_ii = ai * bi;
  assign p_ri = ar * bi;
  assign p_ir = ai * br;

  // Conjugating b flips the sign of every bi term; negating the products avoids -(-128) overflow.
  always_comb begin
    if (conj_b) begin
      re_p = (2*DW+1)'(p_rr) + (2*DW+1)'(p_ii);
      im_p = (2*DW+1)'(p_ir) - (2*DW+1)'(p_ri);
    end else begin
      re_p = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
      im_p = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);
    end
    re_ext  = ACC_W'(re_p);
    im_ext  = ACC_W'(im_p);
    re_base = clr ? '0 : re_q;
    im_base = clr ? '0 : im_q;
    re_d    = re_base + re_ext;
    im_d    = im_base + im_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign acc = {re_q, im_q};

endmodule

// File: rtl/convcor_sched.sv
// Frame capture, product scheduling onto one cplx_mac, result buffering and output streaming.
module convcor_sched #(
  parameter int unsigned DW    = convcor_pkg::DW,
  parameter int unsigned ACC_W = convcor_pkg::ACC_W,
  parameter int unsigned N     = convcor_pkg::N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2*DW-1:0]      in_a,
  input  logic [2*DW-1:0]      in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  output logic [2*ACC_W-1:0]   out,
  output logic                 busy
);
  import convcor_pkg::*;

  localparam int unsigned NOUT = 2*N - 1;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned RW   = $clog2(NOUT);

  state_e              state_q, state_d;
  logic                in_valid_q, mode_q, pend_q;
  logic [IW-1:0]       cnt_q, cnt_d, k_q, k_d;
  logic [RW-1:0]       n_q, n_d, rd_q, rd_d, pend_idx_q;
  logic [2*DW-1:0]     a_q [N];
  logic [2*DW-1:0]     b_q [N];
  logic [2*ACC_W-1:0]  res_q [NOUT];

  logic                start, corr, mac_en, mac_clr, k_done, n_done;
  logic [IW-1:0]       k_first, k_last, k_first_nx, b_idx;
  logic [RW-1:0]       n_last;
  logic [2*ACC_W-1:0]  acc, word;

  assign start = (state_q == S_IDLE) && in_valid && !in_valid_q;
  assign corr  = (mode_q == MODE_CORR);

  always_comb begin
    if (corr) begin
      k_first    = '0;
      k_last     = IW'(N - 1);
      k_first_nx = '0;
      n_last     = '0;
      b_idx      = k_q;
    end else begin
      k_first    = IW'(conv_k_first(32'(n_q), N));
      k_last     = IW'(conv_k_last(32'(n_q), N));
      k_first_nx = IW'(conv_k_first(32'(n_q) + 32'd1, N));
      n_last     = RW'(NOUT - 1);
      b_idx      = IW'(n_q - RW'(k_q));
    end
    k_done = (k_q == k_last);
    n_done = (n_q == n_last);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    n_d     = n_q;
    rd_d    = rd_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = IW'(1);
        end
      end
      S_LOAD: begin
        if (!in_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == IW'(N - 1)) begin
          state_d = S_COMPUTE;
          n_d     = '0;
          k_d     = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      S_COMPUTE: begin
        mac_en  = 1'b1;
        mac_clr = (k_q == k_first);
        if (!k_done) begin
          k_d = k_q + IW'(1);
        end else if (!n_done) begin
          n_d = n_q + RW'(1);
          k_d = k_first_nx;
        end else begin
          state_d = S_OUTPUT;
          rd_d    = '0;
        end
      end
      S_OUTPUT: begin
        if (rd_q == n_last) begin
          state_d = S_IDLE;
          rd_d    = '0;
        end else begin
          rd_d = rd_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  cplx_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .conj_b (corr),
    .a      (a_q[k_q]),
    .b      (b_q[b_idx]),
    .acc    (acc)
  );

  // The accumulator is registered, so y[n-1] is banked when n's first product clears it;
  // the final word is banked one cycle late and forwarded from acc until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_valid_q <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      k_q        <= '0;
      n_q        <= '0;
      rd_q       <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NOUT; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      n_q        <= n_d;
      rd_q       <= rd_d;
      if (start) begin
        a_q[0] <= in_a;
        b_q[0] <= in_b;
        mode_q <= in_mode;
      end
      if (state_q == S_LOAD && in_valid) begin
        a_q[cnt_q] <= in_a;
        b_q[cnt_q] <= in_b;
      end
      if (mac_clr && n_q != '0) begin
        res_q[n_q - RW'(1)] <= acc;
      end
      if (mac_en && k_done && n_done) begin
        pend_q     <= 1'b1;
        pend_idx_q <= n_q;
      end else if (pend_q && state_q == S_OUTPUT) begin
        res_q[pend_idx_q] <= acc;
        pend_q            <= 1'b0;
      end
    end
  end

  assign word      = (pend_q && rd_q == pend_idx_q) ? acc : res_q[rd_q];
  assign out_valid = (state_q == S_OUTPUT);
  assign out       = out_valid ? word : '0;
  assign busy      = (state_q != S_IDLE) || start;

endmodule

// File: tb/tb_convcor_sched.sv
// Directed and back-to-back random checks of convcor_sched against hand values and a reference model.
module tb_convcor_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        in_mode;
  logic        out_valid;
  logic [35:0] out_w;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] fa [3];
  logic [15:0] fb [3];

  always #5 clk = ~clk;

  convcor_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out       (out_w),
    .busy      (busy)
  );

  task automatic release_inputs();
    in_valid = 1'b0;
    in_a     = 'x;
    in_b     = 'x;
    in_mode  = 1'bx;
  endtask

  // Leaves the third sample on the bus; the caller's cycle loop then runs from L+1.
  task automatic send_frame(input logic m, input logic [15:0] a0, a1, a2, b0, b1, b2);
    fa[0] = a0; fa[1] = a1; fa[2] = a2;
    fb[0] = b0; fb[1] = b1; fb[2] = b2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = fa[i];
      in_b     = fb[i];
      in_mode  = (i == 0) ? m : 1'bx;
    end
  endtask

  function automatic logic [35:0] model_word(input logic m, input int n);
    int re, im, d, ar, ai, br, bi;
    re = 0;
    im = 0;
    for (int k = 0; k < 3; k++) begin
      d = m ? k : n - k;
      if (d >= 0 && d <= 2) begin
        ar = int'($signed(fa[k][15:8]));
        ai = int'($signed(fa[k][7:0]));
        br = int'($signed(fb[d][15:8]));
        bi = int'($signed(fb[d][7:0]));
        if (m) begin
          re += ar*br + ai*bi;
          im += ai*br - ar*bi;
        end else begin
          re += ar*br - ai*bi;
          im += ar*bi + ai*br;
        end
      end
    end
    return {re[17:0], im[17:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_w !== 36'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b out=%h busy=%b, want 0/0/0", out_valid, out_w, busy);
    end
    rst_n = 1'b1;
    send_frame(1'b0, 16'h0101, 16'h0202, 16'h0303, 16'h0101, 16'h0101, 16'h0101);
    vectors++;
    if (out_valid !== 1'b0 || out_w !== 36'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_input_cycle: valid=%b out=%h busy=%b, want 0/0/1", out_valid, out_w, busy);
    end
    @(posedge clk); #1;
    release_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || out_w !== 36'd0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_midframe_quiet: cyc=%0d valid=%b out=%h busy=%b, want 0/0/0", j, out_valid, out_w, busy);
      end
    end
  endtask

  task automatic test_convolution();
    logic [35:0] want [5];
    want = '{{18'd1, 18'd0}, {18'd3, 18'd0}, {18'd6, 18'd0}, {18'd5, 18'd0}, {18'd3, 18'd0}};
    send_frame(1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100);
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
      vectors++;
      if (out_valid !== (j >= 10 && j <= 14)) begin
        miscompares++;
        $display("FAIL conv_valid: L+%0d got %b want %b", j, out_valid, (j >= 10 && j <= 14));
      end
      vectors++;
      if (j >= 10 && j <= 14) begin
        if (out_w !== want[j-10]) begin
          miscompares++;
          $display("FAIL conv_word: L+%0d got %h want %h", j, out_w, want[j-10]);
        end
      end else if (out_w !== 36'd0) begin
        miscompares++;
        $display("FAIL conv_idle_out: L+%0d got %h want 0", j, out_w);
      end
      vectors++;
      if (busy !== (j <= 14)) begin
        miscompares++;
        $display("FAIL conv_busy: L+%0d got %b want %b", j, busy, (j <= 14));
      end
    end
  endtask

  task automatic test_correlation();
    send_frame(1'b1, 16'h0101, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
      vectors++;
      if (out_valid !== (j == 4)) begin
        miscompares++;
        $display("FAIL corr_valid: L+%0d got %b want %b", j, out_valid, (j == 4));
      end
      vectors++;
      if (out_w !== ((j == 4) ? {18'd1, 18'h3FFFF} : 36'd0)) begin
        miscompares++;
        $display("FAIL corr_word: L+%0d got %h want %h", j, out_w, (j == 4) ? {18'd1, 18'h3FFFF} : 36'd0);
      end
      vectors++;
      if (busy !== (j <= 4)) begin
        miscompares++;
        $display("FAIL corr_busy: L+%0d got %b want %b", j, busy, (j <= 4));
      end
    end
  endtask

  // Also pulses in_valid with junk during the convolution's compute phase, which must be ignored.
  task automatic test_extremes();
    logic [35:0] want [5];
    want = '{{18'd0, 18'd32768}, {18'd0, 18'd65536}, {18'd0, 18'd98304}, {18'd0, 18'd65536}, {18'd0, 18'd32768}};
    send_frame(1'b1, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
    end
    vectors++;
    if (out_valid !== 1'b1 || out_w !== {18'd98304, 18'd0}) begin
      miscompares++;
      $display("FAIL extreme_corr: valid=%b out=%h want 1/%h", out_valid, out_w, {18'd98304, 18'd0});
    end
    send_frame(1'b0, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
      if (j == 3) begin in_valid = 1'b1; in_a = 16'h7F7F; in_b = 16'h7F7F; in_mode = 1'b1; end
      if (j == 6) release_inputs();
      if (j >= 10) begin
        vectors++;
        if (out_valid !== 1'b1 || out_w !== want[j-10]) begin
          miscompares++;
          $display("FAIL extreme_conv: L+%0d valid=%b out=%h want 1/%h", j, out_valid, out_w, want[j-10]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [35:0] want [5];
    want = '{{18'd0, 18'd1}, {18'd0, 18'd2}, {18'd0, 18'd3}, {18'd0, 18'd2}, {18'd0, 18'd1}};
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h0505; in_b = 16'h0606; in_mode = 1'b0;
    @(posedge clk); #1;
    in_a = 16'h0707; in_b = 16'h0808;
    @(posedge clk); #1;
    release_inputs();
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet: cyc=%0d valid=%b busy=%b want 0/0", j, out_valid, busy);
      end
    end
    send_frame(1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0001, 16'h0001, 16'h0001);
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
      vectors++;
      if (out_valid !== (j >= 10)) begin
        miscompares++;
        $display("FAIL abort_next_valid: L+%0d got %b want %b", j, out_valid, (j >= 10));
      end
      if (j >= 10) begin
        vectors++;
        if (out_w !== want[j-10]) begin
          miscompares++;
          $display("FAIL abort_next_word: L+%0d got %h want %h", j, out_w, want[j-10]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_output();
    send_frame(1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
    end
    vectors++;
    if (out_valid !== 1'b1 || out_w !== {18'd6, 18'd0}) begin
      miscompares++;
      $display("FAIL midout_word2: valid=%b out=%h want 1/%h", out_valid, out_w, {18'd6, 18'd0});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_w !== 36'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midout_reset: valid=%b out=%h busy=%b want 0/0/0", out_valid, out_w, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b1, 16'h0200, 16'h0003, 16'h0000, 16'h0100, 16'h0101, 16'h0000);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      if (j == 1) release_inputs();
      vectors++;
      if (out_valid !== (j == 4) || out_w !== ((j == 4) ? {18'd5, 18'd3} : 36'd0)) begin
        miscompares++;
        $display("FAIL midout_next: L+%0d valid=%b out=%h want %b/%h", j, out_valid, out_w,
                 (j == 4), (j == 4) ? {18'd5, 18'd3} : 36'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        m;
    int          first;
    logic [35:0] want;
    for (int f = 0; f < 200; f++) begin
      m = 1'($urandom_range(0, 1));
      send_frame(m, 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom));
      first = m ? 4 : 10;
      for (int j = 1; j <= (m ? 4 : 14); j++) begin
        @(posedge clk); #1;
        if (j == 1) release_inputs();
        vectors++;
        if (out_valid !== (j >= first)) begin
          miscompares++;
          $display("FAIL b2b_valid: frame=%0d L+%0d got %b want %b", f, j, out_valid, (j >= first));
        end
        if (j >= first) begin
          want = model_word(m, j - first);
          vectors++;
          if (out_w !== want) begin
            miscompares++;
            $display("FAIL b2b_word: frame=%0d mode=%b idx=%0d got %h want %h", f, m, j - first, out_w, want);
          end
        end
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end_idle: busy=%b valid=%b want 0/0", busy, out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    release_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_convolution();
    repeat (3) @(posedge clk);
    test_correlation();
    repeat (3) @(posedge clk);
    test_extremes();
    repeat (3) @(posedge clk);
    test_abort();
    repeat (3) @(posedge clk);
    test_reset_mid_output();
    repeat (3) @(posedge clk);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
